// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART receiver.
// Imported by the receiver top module and its testbench.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Serial-side and byte-side signals of the UART receiver.
// The slave modport belongs to the receiver, master to its user.
interface uart_rx_core_if;
  import uart_pkg::*;

  logic                 rx_in;
  logic                 rx_enable_signal;
  logic                 rx_done_signal;
  logic [DATA_BITS-1:0] rx_data;

  modport slave (
    input  rx_in,
    input  rx_enable_signal,
    output rx_done_signal,
    output rx_data
  );

  modport master (
    output rx_in,
    output rx_enable_signal,
    input  rx_done_signal,
    input  rx_data
  );

endinterface

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser for the serial line plus a falling-edge
// detector on the synchronised value. All flops reset to idle-high.
module uart_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic fall_o
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q <= 3'b111;
    end else begin
      sh_q <= sh_d;
    end
  end

  // sh_q[1] is the synchronised line, sh_q[2] its previous value
  assign sync_o = sh_q[1];
  assign fall_o = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: centre-sampling FSM, baud counter and shift
// register; emits each good byte with a one-cycle done strobe.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 200_000_000,
  parameter int BAUD_RATE = 1_000_000
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_core_if.slave  bus
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB);
  localparam int IW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic line;
  logic fall;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  uart_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.rx_in),
    .sync_o (line),
    .fall_o (fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;

    if (state_q != IDLE && !bus.rx_enable_signal) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (bus.rx_enable_signal && fall) begin
            state_d = START;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            idx_d = '0;
            // high at mid start bit means a glitch
            state_d = line ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d          = '0;
            shreg_d[idx_q] = line;
            if (idx_q == IDX_LAST) begin
              state_d = STOP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (line) begin
              data_d  = shreg_q;
              state_d = DONE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
    end
  end

  assign bus.rx_done_signal = (state_q == DONE);
  assign bus.rx_data        = data_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 200 MHz / 1 Mbit/s.
// Frames are driven with real-time bit periods off the clock edges.
`timescale 1ns/1ps
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int BIT_NS = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_core_if bus ();

  uart_rx_core #(
    .CLK_FREQ  (200_000_000),
    .BAUD_RATE (1_000_000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #2.5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         strobes   = 0;
  int         cur_width = 0;
  int         max_width = 0;
  logic [7:0] seen[$];

  always @(negedge clk) begin
    if (bus.rx_done_signal === 1'b1) begin
      strobes++;
      seen.push_back(bus.rx_data);
      cur_width++;
      if (cur_width > max_width) max_width = cur_width;
    end else begin
      cur_width = 0;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seen_at(input int i);
    if (i < 0 || i >= seen.size()) return 8'hxx;
    return seen[i];
  endfunction

  // drop_bit >= 0 lowers the enable halfway through that data bit
  task automatic send_frame(
    input logic [7:0] d,
    input logic       stop_bit,
    input int         drop_bit
  );
    bus.rx_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = d[i];
      if (i == drop_bit) begin
        #(BIT_NS / 2);
        bus.rx_enable_signal = 1'b0;
        #(BIT_NS / 2);
      end else begin
        #(BIT_NS);
      end
    end
    bus.rx_in = stop_bit;
    #(BIT_NS);
    bus.rx_in = 1'b1;
  endtask

  task automatic expect_byte(
    input string      tag,
    input logic [7:0] d
  );
    int n;
    n = strobes;
    send_frame(d, 1'b1, -1);
    #100;
    chk({tag, "_strobes"}, 32'(strobes), 32'(n + 1));
    chk({tag, "_seen"}, 32'(seen_at(n)), 32'(d));
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'(d));
  endtask

  int n0;

  initial begin
    bus.rx_in            = 1'b1;
    bus.rx_enable_signal = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", 32'(bus.rx_data), 32'h00);
    chk("reset_done", 32'(bus.rx_done_signal), 32'h0);
    chk("reset_state", 32'(dut.state_q), 32'(IDLE));

    rst                  = 1'b1;
    bus.rx_enable_signal = 1'b1;
    #100_000;
    chk("idle_strobes", 32'(strobes), 32'd0);

    expect_byte("b55_a", 8'h55);
    chk("b55_width", 32'(max_width), 32'd1);
    #(110_000 - 10 * BIT_NS - 100);
    expect_byte("b55_b", 8'h55);

    n0 = strobes;
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    #100;
    chk("b2b_strobes", 32'(strobes), 32'(n0 + 3));
    chk("b2b_a3", 32'(seen_at(n0)), 32'hA3);
    chk("b2b_00", 32'(seen_at(n0 + 1)), 32'h00);
    chk("b2b_ff", 32'(seen_at(n0 + 2)), 32'hFF);

    n0 = strobes;
    bus.rx_in = 1'b0;
    #200;
    bus.rx_in = 1'b1;
    #2000;
    chk("glitch_strobes", 32'(strobes), 32'(n0));
    chk("glitch_state", 32'(dut.state_q), 32'(IDLE));
    expect_byte("b3c", 8'h3C);

    n0 = strobes;
    send_frame(8'h81, 1'b0, -1);
    #2000;
    chk("frame_err_strobes", 32'(strobes), 32'(n0));
    chk("frame_err_data", 32'(bus.rx_data), 32'h3C);
    expect_byte("b42", 8'h42);

    n0 = strobes;
    send_frame(8'h99, 1'b1, 4);
    #100;
    chk("en_drop_strobes", 32'(strobes), 32'(n0));
    chk("en_drop_state", 32'(dut.state_q), 32'(IDLE));
    chk("en_drop_data", 32'(bus.rx_data), 32'h42);
    bus.rx_enable_signal = 1'b1;
    #2000;

    bus.rx_in = 1'b0;
    #(BIT_NS);
    bus.rx_in = 1'b0;
    #(BIT_NS);
    bus.rx_in = 1'b1;
    #(BIT_NS);
    bus.rx_in = 1'b1;
    #400;
    @(negedge clk);
    chk("mid_state", 32'(dut.state_q), 32'(DATA));
    rst       = 1'b0;
    bus.rx_in = 1'b1;
    @(negedge clk);
    chk("rst_mid_data", 32'(bus.rx_data), 32'h00);
    chk("rst_mid_done", 32'(bus.rx_done_signal), 32'h0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    #2000;
    expect_byte("bc5", 8'hC5);

    chk("pulse_width", 32'(max_width), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
